// File: rtl/bcd_stopwatch_ctrl.sv
// bcd_stopwatch_ctrl: run/pause/clear controller for a 3-digit BCD count (000-999)
// driven by a prescaled tick, with active-low 7-segment decode of each digit.
// Latency: a key first sampled low at edge k acts at edge k+2 (plus DEB_CYC with debounce).
// Backpressure: none; presses while a key is held do not repeat, and SS in DONE is ignored.
//
// Ports:
//   Clock, Resetn        system clock and asynchronous active-low reset
//   KeyStartStop         raw active-low pushbutton (start/pause/resume), async to Clock
//   KeyClear             raw active-low pushbutton (clear), async to Clock
//   BCD[11:0]            count: [11:8] hundreds, [7:4] tens, [3:0] ones
//   HEX0/HEX1/HEX2[0:6]  ones/tens/hundreds segments, active-low, bit 0 = a .. bit 6 = g
//   Running, Done        high in RUN / DONE state (registered)
//
// Optional build macro STOPWATCH_DEBOUNCE_EN inserts a DEB_CYC-cycle debouncer
// between each key synchronizer and its press detector.
module bcd_stopwatch_ctrl #(
  parameter int DIV   = 50000000,
  parameter int DIV_W = 26
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        KeyStartStop,
  input  logic        KeyClear,
  output logic [11:0] BCD,
  output logic [0:6]  HEX0,
  output logic [0:6]  HEX1,
  output logic [0:6]  HEX2,
  output logic        Running,
  output logic        Done
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE} state_e;

  state_e           state_q, state_d;
  logic [3:0]       ones_q, tens_q, hund_q;
  logic [3:0]       ones_d, tens_d, hund_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic             running_q, done_q;

  logic ss_s1_q, ss_s2_q, clr_s1_q, clr_s2_q;
  logic ss_prev_q, clr_prev_q;
  logic ss_k, clr_k;

`ifdef STOPWATCH_DEBOUNCE_EN
  localparam int DEB_CYC = 1000000;
  localparam int DEB_W   = $clog2(DEB_CYC);

  logic             ss_deb_q, clr_deb_q;
  logic [DEB_W-1:0] ss_cnt_q, clr_cnt_q;

  // Output flips only after the synced key has disagreed with it for DEB_CYC
  // consecutive cycles; any agreement in between restarts the count.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      ss_deb_q  <= 1'b1;
      clr_deb_q <= 1'b1;
      ss_cnt_q  <= '0;
      clr_cnt_q <= '0;
    end else begin
      if (ss_s2_q == ss_deb_q) begin
        ss_cnt_q <= '0;
      end else if (ss_cnt_q == DEB_W'(DEB_CYC - 1)) begin
        ss_deb_q <= ss_s2_q;
        ss_cnt_q <= '0;
      end else begin
        ss_cnt_q <= ss_cnt_q + 1'b1;
      end
      if (clr_s2_q == clr_deb_q) begin
        clr_cnt_q <= '0;
      end else if (clr_cnt_q == DEB_W'(DEB_CYC - 1)) begin
        clr_deb_q <= clr_s2_q;
        clr_cnt_q <= '0;
      end else begin
        clr_cnt_q <= clr_cnt_q + 1'b1;
      end
    end
  end

  assign ss_k  = ss_deb_q;
  assign clr_k = clr_deb_q;
`else
  assign ss_k  = ss_s2_q;
  assign clr_k = clr_s2_q;
`endif

  // Falling edge of the conditioned key = one press pulse; clear beats start/stop.
  logic ss_pulse, clr_pulse, ss_go;
  assign ss_pulse  = ss_prev_q & ~ss_k;
  assign clr_pulse = clr_prev_q & ~clr_k;
  assign ss_go     = ss_pulse & ~clr_pulse;

  logic tick, at_max;
  assign tick   = (state_q == ST_RUN) && (presc_q == DIV_W'(DIV - 1));
  assign at_max = (hund_q == 4'd9) && (tens_q == 4'd9) && (ones_q == 4'd9);

  always_comb begin
    state_d = state_q;
    ones_d  = ones_q;
    tens_d  = tens_q;
    hund_d  = hund_q;
    presc_d = presc_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_pulse) begin
          {hund_d, tens_d, ones_d} = '0;
          presc_d = '0;
        end else if (ss_go) begin
          state_d = ST_RUN;
          presc_d = '0;
        end
      end
      ST_RUN: begin
        if (clr_pulse) begin
          {hund_d, tens_d, ones_d} = '0;
          presc_d = '0;
        end else if (tick) begin
          presc_d = '0;
          if (at_max) begin
            state_d = ST_DONE;
          end else begin
            if (ss_go) state_d = ST_PAUSE;
            if (ones_q == 4'd9) begin
              ones_d = 4'd0;
              if (tens_q == 4'd9) begin
                tens_d = 4'd0;
                hund_d = hund_q + 4'd1;
              end else begin
                tens_d = tens_q + 4'd1;
              end
            end else begin
              ones_d = ones_q + 4'd1;
            end
          end
        end else if (ss_go) begin
          // Prescaler is frozen on the pause edge so resume continues exactly.
          state_d = ST_PAUSE;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      ST_PAUSE: begin
        if (clr_pulse) begin
          state_d = ST_IDLE;
          {hund_d, tens_d, ones_d} = '0;
          presc_d = '0;
        end else if (ss_go) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (clr_pulse) begin
          state_d = ST_IDLE;
          {hund_d, tens_d, ones_d} = '0;
          presc_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q    <= ST_IDLE;
      ones_q     <= 4'd0;
      tens_q     <= 4'd0;
      hund_q     <= 4'd0;
      presc_q    <= '0;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      ss_s1_q    <= 1'b1;
      ss_s2_q    <= 1'b1;
      clr_s1_q   <= 1'b1;
      clr_s2_q   <= 1'b1;
      ss_prev_q  <= 1'b1;
      clr_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      ones_q     <= ones_d;
      tens_q     <= tens_d;
      hund_q     <= hund_d;
      presc_q    <= presc_d;
      running_q  <= (state_d == ST_RUN);
      done_q     <= (state_d == ST_DONE);
      ss_s1_q    <= KeyStartStop;
      ss_s2_q    <= ss_s1_q;
      clr_s1_q   <= KeyClear;
      clr_s2_q   <= clr_s1_q;
      ss_prev_q  <= ss_k;
      clr_prev_q <= clr_k;
    end
  end

  // Pattern is written a..g from MSB down, so it lands on HEX[0]=a .. HEX[6]=g.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b0000001;
      4'd1:    seg7 = 7'b1001111;
      4'd2:    seg7 = 7'b0010010;
      4'd3:    seg7 = 7'b0000110;
      4'd4:    seg7 = 7'b1001100;
      4'd5:    seg7 = 7'b0100100;
      4'd6:    seg7 = 7'b1100000;
      4'd7:    seg7 = 7'b0001111;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0001100;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  assign BCD     = {hund_q, tens_q, ones_q};
  assign HEX0    = seg7(ones_q);
  assign HEX1    = seg7(tens_q);
  assign HEX2    = seg7(hund_q);
  assign Running = running_q;
  assign Done    = done_q;

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Bench for bcd_stopwatch_ctrl with DIV=4: expected BCD values are queued as
// stimulus is driven and a negedge monitor pops one per observed BCD change;
// scenario tasks add inline timing/state checks.
module tb_bcd_stopwatch_ctrl;
  localparam int DIV = 4;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic        KeyStartStop = 1'b1;
  logic        KeyClear = 1'b1;
  logic [11:0] BCD;
  logic [0:6]  HEX0, HEX1, HEX2;
  logic        Running, Done;

  int checks = 0;
  int errors = 0;
  int cur = 0;
  logic [11:0] exp_q[$];
  logic [11:0] last_bcd = 12'h000;
  logic [11:0] mon_exp;
  bit mon_en = 1'b0;

  bcd_stopwatch_ctrl #(.DIV(DIV), .DIV_W(3)) dut (
    .Clock(Clock), .Resetn(Resetn), .KeyStartStop(KeyStartStop), .KeyClear(KeyClear),
    .BCD(BCD), .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .Running(Running), .Done(Done)
  );

  always #5 Clock = ~Clock;

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Scoreboard: every BCD change must match the next queued expectation.
  always @(negedge Clock) begin
    if (mon_en && (BCD !== last_bcd)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL bcd_unexpected_change got %h, nothing expected (was %h)", BCD, last_bcd);
      end else begin
        mon_exp = exp_q.pop_front();
        if (BCD !== mon_exp) begin
          errors++;
          $display("FAIL bcd_sequence got %h expected %h", BCD, mon_exp);
        end
      end
      last_bcd = BCD;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  // Call between a negedge and the next posedge; returns just before the update edge (k+2).
  task automatic do_press(input bit ss, input bit clr);
    KeyStartStop = ~ss;
    KeyClear = ~clr;
    @(negedge Clock);
    @(negedge Clock);
    KeyStartStop = 1'b1;
    KeyClear = 1'b1;
  endtask

  task automatic run_to(input int target);
    int bound;
    bound = (target - cur) * DIV + 20;
    for (int v = cur + 1; v <= target; v++) exp_q.push_back(to_bcd(v));
    for (int i = 0; i < bound && BCD !== to_bcd(target); i++) @(negedge Clock);
    #1;
    checks++;
    if (BCD !== to_bcd(target)) begin
      errors++;
      $display("FAIL run_to_timeout got %h expected %h", BCD, to_bcd(target));
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    cur = target;
  endtask

  task automatic test_reset();
    Resetn = 1'b0;
    repeat (3) @(negedge Clock);
    Resetn = 1'b1;
    repeat (100) @(negedge Clock);
    checks++; if (BCD !== 12'h000) begin errors++; $display("FAIL reset_bcd got %h expected 000", BCD); end
    checks++; if (HEX0 !== 7'b0000001) begin errors++; $display("FAIL reset_hex0 got %b expected 0000001", HEX0); end
    checks++; if (HEX1 !== 7'b0000001) begin errors++; $display("FAIL reset_hex1 got %b expected 0000001", HEX1); end
    checks++; if (HEX2 !== 7'b0000001) begin errors++; $display("FAIL reset_hex2 got %b expected 0000001", HEX2); end
    checks++; if (Running !== 1'b0) begin errors++; $display("FAIL reset_running got %b expected 0", Running); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", Done); end
    last_bcd = 12'h000;
    mon_en = 1'b1;
    cur = 0;
  endtask

  task automatic test_start();
    do_press(1'b1, 1'b0);
    checks++; if (Running !== 1'b0) begin errors++; $display("FAIL start_early got Running=%b expected 0", Running); end
    @(negedge Clock);
    checks++; if (Running !== 1'b1) begin errors++; $display("FAIL start_k2 got Running=%b expected 1", Running); end
    exp_q.push_back(12'h001);
    repeat (3) @(negedge Clock);
    checks++; if (BCD !== 12'h000) begin errors++; $display("FAIL first_tick_early got %h expected 000", BCD); end
    @(negedge Clock);
    checks++; if (BCD !== 12'h001) begin errors++; $display("FAIL first_tick got %h expected 001", BCD); end
    cur = 1;
  endtask

  task automatic test_count();
    test_start();
    run_to(9);
    run_to(10);
    checks++; if (HEX1 !== 7'b1001111 || HEX0 !== 7'b0000001) begin errors++; $display("FAIL hex_010 got %b %b expected 1001111 0000001", HEX1, HEX0); end
    run_to(99);
    checks++; if (HEX1 !== 7'b0001100 || HEX0 !== 7'b0001100) begin errors++; $display("FAIL hex_099 got %b %b expected 0001100 0001100", HEX1, HEX0); end
    run_to(100);
    checks++; if (BCD !== 12'h100) begin errors++; $display("FAIL carry_100 got %h expected 100", BCD); end
    checks++; if (HEX2 !== 7'b1001111 || HEX1 !== 7'b0000001) begin errors++; $display("FAIL hex_100 got %b %b expected 1001111 0000001", HEX2, HEX1); end
  endtask

  // Clear lands on a tick edge at 123: the clear must win and restart the prescaler.
  task automatic test_clear_run();
    run_to(123);
    @(negedge Clock);
    exp_q.push_back(12'h000);
    do_press(1'b0, 1'b1);
    checks++; if (BCD !== 12'h123) begin errors++; $display("FAIL clr_pre got %h expected 123", BCD); end
    @(negedge Clock);
    checks++; if (BCD !== 12'h000) begin errors++; $display("FAIL clr_tick_same got %h expected 000", BCD); end
    checks++; if (Running !== 1'b1) begin errors++; $display("FAIL clr_run_state got Running=%b expected 1", Running); end
    exp_q.push_back(12'h001);
    repeat (3) @(negedge Clock);
    checks++; if (BCD !== 12'h000) begin errors++; $display("FAIL clr_presc_early got %h expected 000", BCD); end
    @(negedge Clock);
    checks++; if (BCD !== 12'h001) begin errors++; $display("FAIL clr_presc_tick got %h expected 001", BCD); end
    cur = 1;
  endtask

  task automatic test_pause();
    run_to(5);
    do_press(1'b1, 1'b0);   // update edge sees prescaler = 2
    @(negedge Clock);
    checks++; if (Running !== 1'b0 || BCD !== 12'h005) begin errors++; $display("FAIL pause_enter got Running=%b BCD=%h expected 0 005", Running, BCD); end
    repeat (50) @(negedge Clock);
    checks++; if (BCD !== 12'h005) begin errors++; $display("FAIL pause_hold got %h expected 005", BCD); end
    exp_q.push_back(12'h006);
    do_press(1'b1, 1'b0);
    @(negedge Clock);
    checks++; if (Running !== 1'b1) begin errors++; $display("FAIL resume got Running=%b expected 1", Running); end
    @(negedge Clock);
    checks++; if (BCD !== 12'h005) begin errors++; $display("FAIL resume_early got %h expected 005", BCD); end
    @(negedge Clock);
    checks++; if (BCD !== 12'h006) begin errors++; $display("FAIL resume_tick got %h expected 006", BCD); end
    cur = 6;
  endtask

  task automatic test_ss_clr_same();
    run_to(42);
    do_press(1'b1, 1'b0);
    @(negedge Clock);
    checks++; if (Running !== 1'b0 || BCD !== 12'h042) begin errors++; $display("FAIL pause_042 got Running=%b BCD=%h expected 0 042", Running, BCD); end
    repeat (5) @(negedge Clock);
    exp_q.push_back(12'h000);
    do_press(1'b1, 1'b1);
    @(negedge Clock);
    checks++; if (Running !== 1'b0 || Done !== 1'b0) begin errors++; $display("FAIL ss_clr_state got Running=%b Done=%b expected 0 0", Running, Done); end
    checks++; if (BCD !== 12'h000) begin errors++; $display("FAIL ss_clr_bcd got %h expected 000", BCD); end
    cur = 0;
    repeat (5) @(negedge Clock);
    do_press(1'b0, 1'b1);
    @(negedge Clock);
    checks++; if (Running !== 1'b0 || BCD !== 12'h000) begin errors++; $display("FAIL idle_clr got Running=%b BCD=%h expected 0 000", Running, BCD); end
    repeat (5) @(negedge Clock);
  endtask

  task automatic test_tick_ss_same();
    test_start();
    run_to(7);
    @(negedge Clock);
    exp_q.push_back(12'h008);
    do_press(1'b1, 1'b0);
    @(negedge Clock);
    checks++; if (BCD !== 12'h008) begin errors++; $display("FAIL tick_ss_bcd got %h expected 008", BCD); end
    checks++; if (Running !== 1'b0) begin errors++; $display("FAIL tick_ss_pause got Running=%b expected 0", Running); end
    repeat (5) @(negedge Clock);
    do_press(1'b1, 1'b0);
    @(negedge Clock);
    checks++; if (Running !== 1'b1) begin errors++; $display("FAIL tick_ss_resume got Running=%b expected 1", Running); end
    cur = 8;
  endtask

  task automatic test_reset_mid();
    run_to(777);
    checks++; if (HEX2 !== 7'b0001111 || HEX1 !== 7'b0001111 || HEX0 !== 7'b0001111) begin errors++; $display("FAIL hex_777 got %b %b %b expected 0001111 x3", HEX2, HEX1, HEX0); end
    exp_q.push_back(12'h000);
    #1 Resetn = 1'b0;
    #1;
    checks++; if (BCD !== 12'h000) begin errors++; $display("FAIL async_reset_bcd got %h expected 000", BCD); end
    checks++; if (Running !== 1'b0 || Done !== 1'b0) begin errors++; $display("FAIL async_reset_state got Running=%b Done=%b expected 0 0", Running, Done); end
    @(negedge Clock);
    Resetn = 1'b1;
    repeat (10) @(negedge Clock);
    checks++; if (Running !== 1'b0 || BCD !== 12'h000) begin errors++; $display("FAIL post_reset got Running=%b BCD=%h expected 0 000", Running, BCD); end
    cur = 0;
  endtask

  // Start/stop lands on the tick edge at 999: DONE must win.
  task automatic test_done();
    test_start();
    run_to(999);
    @(negedge Clock);
    do_press(1'b1, 1'b0);
    checks++; if (Done !== 1'b0 || Running !== 1'b1) begin errors++; $display("FAIL done_early got Done=%b Running=%b expected 0 1", Done, Running); end
    @(negedge Clock);
    checks++; if (Done !== 1'b1 || Running !== 1'b0) begin errors++; $display("FAIL done_enter got Done=%b Running=%b expected 1 0", Done, Running); end
    checks++; if (BCD !== 12'h999 || HEX0 !== 7'b0001100) begin errors++; $display("FAIL done_bcd got %h %b expected 999 0001100", BCD, HEX0); end
    repeat (5) @(negedge Clock);
    do_press(1'b1, 1'b0);
    @(negedge Clock);
    checks++; if (Done !== 1'b1 || Running !== 1'b0) begin errors++; $display("FAIL done_ss_ignored got Done=%b Running=%b expected 1 0", Done, Running); end
    repeat (20) @(negedge Clock);
    checks++; if (BCD !== 12'h999) begin errors++; $display("FAIL done_hold got %h expected 999", BCD); end
    exp_q.push_back(12'h000);
    do_press(1'b0, 1'b1);
    @(negedge Clock);
    checks++; if (Done !== 1'b0 || Running !== 1'b0) begin errors++; $display("FAIL done_clr_state got Done=%b Running=%b expected 0 0", Done, Running); end
    checks++; if (BCD !== 12'h000) begin errors++; $display("FAIL done_clr_bcd got %h expected 000", BCD); end
    cur = 0;
  endtask

  initial begin
    test_reset();
    test_count();
    test_clear_run();
    test_pause();
    test_ss_clr_same();
    test_tick_ss_same();
    test_reset_mid();
    test_done();
    repeat (5) @(negedge Clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
